// File: rtl/inference_sequencer_pkg.sv
// Shared definitions for the inference sequencer: FSM state encodings and the
// widths of the state and digit buses.
package inference_sequencer_pkg;

    localparam int unsigned StateW = 3;
    localparam int unsigned DigitW = 4;

    // Encodings are exported on the state output for LED display; keep them fixed.
    typedef enum logic [StateW-1:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StRun   = 3'd2,
        StHold  = 3'd3,
        StError = 3'd4
    } state_e;

    // True in the states where a new trigger is dropped because an inference is in flight.
    function automatic logic is_busy(input state_e s);
        return (s == StStart) || (s == StRun) || (s == StHold);
    endfunction

endpackage

// File: rtl/inference_sequencer_if.sv
// Bundle of every non-clock signal of the inference sequencer.
//   master : the sequencer itself (consumes key/image/core status, drives start and display)
//   slave  : the surrounding system (UART collector, keys, core, HEX/LED display)
// Signals:
//   key_start, auto_mode, image_valid  trigger sources
//   nn_done, nn_argmax                 core completion and classification
//   nn_start                           start request to the core
//   busy, state                        status for LEDs
//   result, result_valid               held classification for HEX display
//   timeout_err, infer_count           watchdog flag and completed-inference counter
interface inference_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    import inference_sequencer_pkg::*;

    logic              key_start;
    logic              auto_mode;
    logic              image_valid;
    logic              nn_done;
    logic [DigitW-1:0] nn_argmax;
    logic              nn_start;
    logic              busy;
    logic [DigitW-1:0] result;
    logic              result_valid;
    logic              timeout_err;
    logic [CNT_W-1:0]  infer_count;
    logic [StateW-1:0] state;

    modport master (
        input  key_start,
        input  auto_mode,
        input  image_valid,
        input  nn_done,
        input  nn_argmax,
        output nn_start,
        output busy,
        output result,
        output result_valid,
        output timeout_err,
        output infer_count,
        output state
    );

    modport slave (
        output key_start,
        output auto_mode,
        output image_valid,
        output nn_done,
        output nn_argmax,
        input  nn_start,
        input  busy,
        input  result,
        input  result_valid,
        input  timeout_err,
        input  infer_count,
        input  state
    );

endinterface

// File: rtl/inference_sequencer_rise_detect.sv
// Single-bit rising-edge detector. The previous-value register resets to 0, so a
// signal already high when reset releases is reported as an edge on the first cycle.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   sig_i   level input (already synchronous to clk_i)
//   rise_o  high in the cycle where sig_i is 1 and was 0 the cycle before
module inference_sequencer_rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/inference_sequencer.sv
// Control FSM between the UART image collector and the neural-network core.
// A new image (auto mode) or a start key with an image present issues a
// START_CYCLES-long start pulse to the core, then waits for done under a watchdog.
// On done the argmax is latched into a held result and the inference counter steps;
// if the watchdog expires the sticky timeout_err is raised until the key is pressed.
// Ports:
//   clk     single clock, rising edge
//   resetn  asynchronous active-low reset (shared with the core)
//   bus     inference_sequencer_if master modport (triggers, core handshake, display)
module inference_sequencer
    import inference_sequencer_pkg::*;
#(
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    inference_sequencer_if.master bus
);

    localparam int unsigned WdogW  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned StartW = $clog2(START_CYCLES + 1);

    localparam logic [WdogW-1:0]  WdogLast  = WdogW'(TIMEOUT_CYCLES - 1);
    localparam logic [StartW-1:0] StartLast = StartW'(START_CYCLES - 1);

    state_e              state_q, state_d;
    logic [StartW-1:0]   start_cnt_q, start_cnt_d;
    logic [WdogW-1:0]    wdog_q, wdog_d;
    logic [DigitW-1:0]   result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic key_rise;
    logic img_rise;
    logic trigger;

    inference_sequencer_rise_detect u_key_rise (
        .clk_i  (clk),
        .rst_ni (resetn),
        .sig_i  (bus.key_start),
        .rise_o (key_rise)
    );

    inference_sequencer_rise_detect u_img_rise (
        .clk_i  (clk),
        .rst_ni (resetn),
        .sig_i  (bus.image_valid),
        .rise_o (img_rise)
    );

    // A key press only counts when a full image is actually held.
    assign trigger = (bus.auto_mode & img_rise) | (key_rise & bus.image_valid);

    always_comb begin
        state_d        = state_q;
        start_cnt_d    = start_cnt_q;
        wdog_d         = wdog_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        timeout_err_d  = timeout_err_q;
        count_d        = count_q;

        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d     = StStart;
                    start_cnt_d = '0;
                end
            end

            StStart: begin
                wdog_d = '0;
                if (start_cnt_q == StartLast) begin
                    state_d = StRun;
                end else begin
                    start_cnt_d = start_cnt_q + StartW'(1);
                end
            end

            StRun: begin
                wdog_d = wdog_q + WdogW'(1);
                // Done takes priority over a watchdog expiring in the same cycle.
                if (bus.nn_done) begin
                    result_d       = bus.nn_argmax;
                    result_valid_d = 1'b1;
                    count_d        = count_q + CNT_W'(1);
                    state_d        = StHold;
                end else if (wdog_q == WdogLast) begin
                    timeout_err_d  = 1'b1;
                    result_valid_d = 1'b0;
                    state_d        = StError;
                end
            end

            // Level-style done must drop before another inference can latch.
            StHold: begin
                if (!bus.nn_done) begin
                    state_d = StIdle;
                end
            end

            StError: begin
                if (key_rise) begin
                    timeout_err_d = 1'b0;
                    state_d       = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= StIdle;
            start_cnt_q    <= '0;
            wdog_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            start_cnt_q    <= start_cnt_d;
            wdog_q         <= wdog_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
            count_q        <= count_d;
        end
    end

    // Status outputs are pure decodes of the state register: no input reaches them
    // combinationally.
    assign bus.nn_start     = (state_q == StStart);
    assign bus.busy         = is_busy(state_q);
    assign bus.state        = state_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.infer_count  = count_q;

endmodule

// File: tb/tb_inference_sequencer.sv
module tb_inference_sequencer;
    import inference_sequencer_pkg::*;

    typedef struct packed {
        logic [3:0] digit;
        logic [7:0] count;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic [7:0] exp_count = 8'd0;

    inference_sequencer_if #(.CNT_W(8)) bus ();

    inference_sequencer #(
        .START_CYCLES   (2),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL sim_guard: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Call in the trigger cycle; returns in the first RUN cycle.
    task automatic expect_start();
        tick();
        bus.key_start = 1'b0;
        check("start_c1", 32'(bus.nn_start), 1);
        check("busy_c1", 32'(bus.busy), 1);
        check("state_start", 32'(bus.state), 32'(StStart));
        tick();
        check("start_c2", 32'(bus.nn_start), 1);
        tick();
        check("start_end", 32'(bus.nn_start), 0);
        check("state_run", 32'(bus.state), 32'(StRun));
    endtask

    // Drive done with a digit this cycle, keep it high for extra cycles, then drop it.
    task automatic do_done(input logic [3:0] d, input int extra);
        exp_t e;
        exp_count = exp_count + 8'd1;
        sb.push_back('{digit: d, count: exp_count});
        bus.nn_done   = 1'b1;
        bus.nn_argmax = d;
        tick();
        e = sb.pop_front();
        check("result", 32'(bus.result), 32'(e.digit));
        check("result_valid", 32'(bus.result_valid), 1);
        check("count", 32'(bus.infer_count), 32'(e.count));
        check("state_hold", 32'(bus.state), 32'(StHold));
        for (int i = 0; i < extra; i++) begin
            tick();
            check("hold_no_relatch", 32'(bus.infer_count), 32'(e.count));
            check("hold_stays", 32'(bus.state), 32'(StHold));
        end
        bus.nn_done   = 1'b0;
        bus.nn_argmax = 4'd0;
        tick();
        check("idle_after_done", 32'(bus.state), 32'(StIdle));
    endtask

    initial begin
        bus.key_start   = 1'b0;
        bus.auto_mode   = 1'b0;
        bus.image_valid = 1'b0;
        bus.nn_done     = 1'b0;
        bus.nn_argmax   = 4'd0;

        // Reset state
        repeat (3) tick();
        check("rst_nn_start", 32'(bus.nn_start), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_result_valid", 32'(bus.result_valid), 0);
        check("rst_timeout", 32'(bus.timeout_err), 0);
        check("rst_count", 32'(bus.infer_count), 0);
        check("rst_state", 32'(bus.state), 32'(StIdle));
        resetn = 1'b1;
        repeat (2) tick();

        // 1. Auto trigger, done ten cycles after the image edge, level done held
        bus.auto_mode   = 1'b1;
        bus.image_valid = 1'b1;
        check("no_comb_start", 32'(bus.nn_start), 0);
        expect_start();
        check("rv_before_done", 32'(bus.result_valid), 0);
        repeat (7) tick();
        do_done(4'd7, 2);
        tick();
        check("no_retrigger_level", 32'(bus.state), 32'(StIdle));

        // 2. Manual mode: key without image ignored, image level alone ignored
        bus.auto_mode   = 1'b0;
        bus.image_valid = 1'b0;
        tick();
        bus.key_start = 1'b1;
        tick();
        bus.key_start = 1'b0;
        check("key_no_image", 32'(bus.state), 32'(StIdle));
        tick();
        check("key_no_image_start", 32'(bus.nn_start), 0);
        bus.image_valid = 1'b1;
        tick();
        check("img_no_auto", 32'(bus.state), 32'(StIdle));
        bus.key_start = 1'b1;
        expect_start();
        do_done(4'd3, 0);

        // 3. Watchdog expiry, result cleared, error ignores images, key clears
        bus.key_start = 1'b1;
        expect_start();
        check("result_persists", 32'(bus.result), 3);
        check("rv_persists", 32'(bus.result_valid), 1);
        repeat (15) tick();
        check("wdog_early", 32'(bus.timeout_err), 0);
        check("wdog_early_state", 32'(bus.state), 32'(StRun));
        tick();
        check("timeout_err", 32'(bus.timeout_err), 1);
        check("timeout_rv", 32'(bus.result_valid), 0);
        check("state_error", 32'(bus.state), 32'(StError));
        bus.auto_mode   = 1'b1;
        bus.image_valid = 1'b0;
        tick();
        bus.image_valid = 1'b1;
        repeat (2) tick();
        check("err_ignores_img", 32'(bus.state), 32'(StError));
        check("err_no_start", 32'(bus.nn_start), 0);
        bus.key_start = 1'b1;
        tick();
        bus.key_start = 1'b0;
        check("err_clear_state", 32'(bus.state), 32'(StIdle));
        check("err_cleared", 32'(bus.timeout_err), 0);
        bus.auto_mode = 1'b0;
        tick();

        // 4. Done on the last watchdog cycle wins over the timeout (digit >9 kept)
        bus.key_start = 1'b1;
        expect_start();
        repeat (15) tick();
        check("last_cycle_no_err", 32'(bus.timeout_err), 0);
        do_done(4'hC, 0);
        check("done_wins_err", 32'(bus.timeout_err), 0);

        // 5. Simultaneous key/image edge = one inference; triggers in RUN dropped
        bus.auto_mode   = 1'b1;
        bus.image_valid = 1'b0;
        tick();
        bus.image_valid = 1'b1;
        bus.key_start   = 1'b1;
        expect_start();
        bus.image_valid = 1'b0;
        tick();
        bus.image_valid = 1'b1;
        tick();
        bus.key_start = 1'b1;
        tick();
        bus.key_start = 1'b0;
        tick();
        check("run_ignores", 32'(bus.state), 32'(StRun));
        do_done(4'd5, 0);
        tick();
        check("no_queue_state", 32'(bus.state), 32'(StIdle));
        check("no_queue_start", 32'(bus.nn_start), 0);

        // Counter wrap 255 -> 0
        bus.auto_mode = 1'b0;
        for (int i = 0; i < 252; i++) begin
            bus.key_start = 1'b1;
            expect_start();
            do_done(4'(i % 10), 0);
        end
        check("wrap_zero", 32'(bus.infer_count), 0);

        // 6. Asynchronous reset in RUN, image high at release triggers
        bus.key_start = 1'b1;
        expect_start();
        repeat (2) tick();
        #2;
        resetn = 1'b0;
        #1;
        exp_count = 8'd0;
        check("arst_nn_start", 32'(bus.nn_start), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_result", 32'(bus.result), 0);
        check("arst_rv", 32'(bus.result_valid), 0);
        check("arst_count", 32'(bus.infer_count), 0);
        check("arst_state", 32'(bus.state), 32'(StIdle));
        bus.auto_mode   = 1'b1;
        bus.image_valid = 1'b1;
        repeat (2) tick();
        resetn = 1'b1;
        expect_start();
        do_done(4'd2, 0);

        check("sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
